onchip_mem_arbiter: RTL and testbench
=====================================

Name: onchip_mem_arbiter

Overview:
- Two-master arbiter for the single-port 32-bit on-chip RAM (13-bit word address, DEPTH words, byte enables, registered address, unregistered q).
- Master 0 is the Nios data master; master 1 is the actuator (verin) logging/DMA engine.
- Issues at most one command per cycle, returns read data with fixed 1-cycle latency, and keeps a saturating conflict counter for debug.

Parameters:
- ADDR_W, 13, word address width
- DATA_W, 32, data width (byte enable width = DATA_W/8)
- DEPTH, 5000, number of implemented words; addresses >= DEPTH are out of range
- FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_address  in  ADDR_W  master 0 word address
- m0_byteenable  in  DATA_W/8  master 0 byte enables
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data strobe
- m1_*  same set as m0_*, for master 1
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  DATA_W/8  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  RAM q (valid 1 cycle after address)
- conflict_count  out  16  saturating count of cycles where both masters requested

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Request definition: reqX = mX_read | mX_write. If read and write are both high, the command is treated as a write and no readdatavalid follows.
- Grant is combinational, one grant per cycle:
  - Only one master requesting: that master is granted.
  - Both requesting, FIXED_PRIO=1: m0 is granted.
  - Both requesting, FIXED_PRIO=0: the master other than last_grant is granted.
  - last_grant register updates on every grant.
- mX_waitrequest = reqX & ~grantX. Waitrequest is 0 when the master is idle.
- Masters must hold their command stable while waitrequest is high.
- Memory command, driven combinationally from the granted master:
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted master.
  - mem_chipselect = grant_any & in_range.
  - mem_write = granted write & in_range.
- No grant: mem_chipselect=0, mem_write=0, mux held on m0 inputs.
- Range check: in_range = (address < DEPTH).
  - Out-of-range write is accepted (waitrequest low) and dropped.
  - Out-of-range read is accepted and returns 0 with normal latency.
- Read return path (registers rd_pend, rd_owner, rd_oor):
  - Set at cycle N when a read is granted.
  - At N+1: mX_readdatavalid=1 for rd_owner only; mX_readdata = rd_oor ? 0 : mem_readdata.
- Back-to-back reads from either master are supported every cycle (fully pipelined, latency exactly 1).
- Readdatavalid is 0 when not pending. Readdata of the non-owner is 0.
- mem_clken = ~reset. The RAM holds its output while reset is high.
- conflict_count increments on each cycle with req0&req1 and saturates at 16'hFFFF.
- Reset values: last_grant=1 (so m0 wins the first conflict), rd_pend=0, rd_owner=0, rd_oor=0, conflict_count=0.
  - Consequently both readdatavalid=0 and both readdata=0 during and after reset.
- Reset mid-operation: a read granted in the cycle reset is high is discarded, with no readdatavalid in the following cycle. A read pending when reset asserts is not returned.
- Writes are posted: the write completes in the grant cycle and no response is generated.
- No combinational path from mem_readdata to any waitrequest.

Test Plan:
- Single master: m0 writes 0xDEADBEEF to address 0x0010 with byteenable 0xF, then reads address 0x0010 -> waitrequest 0 both cycles; m0_readdatavalid exactly 1 cycle after the read with data 0xDEADBEEF; m1 outputs stay 0.
- Byte enable: write 0x11223344 with byteenable 0x5 over 0xFFFFFFFF -> read returns 0xFF22FF44.
- Round-robin contention: both masters issue 4 reads each continuously from reset -> grants alternate m0,m1,m0,m1,...; each master waits exactly 1 cycle per access after the first; conflict_count=7 (the last m1 read sees no contention).
- FIXED_PRIO=1: m0 streams reads for 6 cycles while m1 requests -> m1_waitrequest high all 6 cycles, m1 granted in cycle 7.
- Out-of-range: write to address 5000 then read address 5000 and 4999 -> write not seen at RAM (mem_chipselect=0); read of 5000 returns 0 with valid; 4999 reads normally.
- Reset mid-read: reset asserted in the cycle m1's read is granted -> no m1_readdatavalid next cycle; after release, a conflict grants m0 first; conflict_count=0.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port on-chip RAM (registered address, unregistered q).
// One command per cycle, fixed 1-cycle read return and a saturating debug conflict counter.
module onchip_mem_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 5000,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,

    output logic [15:0]           conflict_count
);

    localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W+1)'(DEPTH);

    logic              req0;
    logic              req1;
    logic              grant0;
    logic              grant1;
    logic              grant_any;
    logic              last_grant;
    logic              sel_read;
    logic              sel_write;
    logic              in_range;
    logic              read_grant;
    logic              rd_pend;
    logic              rd_owner;
    logic              rd_oor;
    logic              ret_valid;
    logic [DATA_W-1:0] ret_data;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // last_grant holds the index of the previously granted master; the other one wins a conflict.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0 && req1) begin
            if ((FIXED_PRIO != 0) || last_grant) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else begin
            grant0 = req0;
            grant1 = req1;
        end
    end

    assign grant_any      = grant0 | grant1;
    assign m0_waitrequest = req0 & ~grant0;
    assign m1_waitrequest = req1 & ~grant1;

    // Without a grant the mux rests on master 0.
    assign mem_address    = grant1 ? m1_address    : m0_address;
    assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
    assign sel_read       = grant1 ? m1_read       : m0_read;
    assign sel_write      = grant1 ? m1_write      : m0_write;

    assign in_range       = {1'b0, mem_address} < DEPTH_LIMIT;
    assign mem_chipselect = grant_any & in_range;
    assign mem_write      = grant_any & sel_write & in_range;
    assign mem_clken      = ~reset;

    // A simultaneous read+write is a write, so it never produces a read return.
    assign read_grant     = grant_any & sel_read & ~sel_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant     <= 1'b1;
            rd_pend        <= 1'b0;
            rd_owner       <= 1'b0;
            rd_oor         <= 1'b0;
            conflict_count <= 16'd0;
        end else begin
            if (grant_any) begin
                last_grant <= grant1;
            end
            rd_pend  <= read_grant;
            rd_owner <= grant1;
            rd_oor   <= ~in_range;
            if (req0 && req1 && (conflict_count != 16'hFFFF)) begin
                conflict_count <= conflict_count + 16'd1;
            end
        end
    end

    // Returns are suppressed while reset is high so a pending read is never delivered across it.
    assign ret_valid        = rd_pend & ~reset;
    assign ret_data         = rd_oor ? '0 : mem_readdata;
    assign m0_readdatavalid = ret_valid & ~rd_owner;
    assign m1_readdatavalid = ret_valid &  rd_owner;
    assign m0_readdata      = m0_readdatavalid ? ret_data : '0;
    assign m1_readdata      = m1_readdatavalid ? ret_data : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: a RAM model, queue-driven masters and a cycle-level
// reference model compared against the round-robin instance, plus a fixed-priority instance.
module tb_onchip_mem_arbiter;

    localparam int DEPTH = 5000;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [12:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } cmd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [12:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;
    logic [15:0] conflict_count;

    onchip_mem_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata), .conflict_count(conflict_count)
    );

    logic [12:0] b_m0_address, b_m1_address;
    logic        b_m0_read, b_m1_read;
    logic        b_m0_waitrequest, b_m1_waitrequest;
    logic [31:0] b_m0_readdata, b_m1_readdata;
    logic        b_m0_readdatavalid, b_m1_readdatavalid;
    logic [12:0] b_mem_address;
    logic [3:0]  b_mem_byteenable;
    logic        b_mem_chipselect, b_mem_write, b_mem_clken;
    logic [31:0] b_mem_writedata;
    logic [15:0] b_conflict_count;

    onchip_mem_arbiter #(.FIXED_PRIO(1)) dut_fixed (
        .clk(clk), .reset(reset),
        .m0_address(b_m0_address), .m0_byteenable(4'hF), .m0_read(b_m0_read),
        .m0_write(1'b0), .m0_writedata(32'd0), .m0_waitrequest(b_m0_waitrequest),
        .m0_readdata(b_m0_readdata), .m0_readdatavalid(b_m0_readdatavalid),
        .m1_address(b_m1_address), .m1_byteenable(4'hF), .m1_read(b_m1_read),
        .m1_write(1'b0), .m1_writedata(32'd0), .m1_waitrequest(b_m1_waitrequest),
        .m1_readdata(b_m1_readdata), .m1_readdatavalid(b_m1_readdatavalid),
        .mem_address(b_mem_address), .mem_byteenable(b_mem_byteenable),
        .mem_chipselect(b_mem_chipselect), .mem_write(b_mem_write),
        .mem_writedata(b_mem_writedata), .mem_clken(b_mem_clken),
        .mem_readdata(32'd0), .conflict_count(b_conflict_count)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] merge_bytes(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] init_word(int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'hA5C30F5A;
    endfunction

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RAM with registered address and unregistered q; frozen while clken is low.
    logic [31:0] ram [0:8191];
    logic [12:0] ram_addr_q = '0;
    assign mem_readdata = ram[ram_addr_q];
    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_clken) begin
                if (mem_chipselect && mem_write)
                    ram[mem_address] <= merge_bytes(ram[mem_address], mem_writedata, mem_byteenable);
                ram_addr_q <= mem_address;
            end
        end
    end

    // Master command queues; a command is held until the arbiter accepts it.
    cmd_t q0[$];
    cmd_t q1[$];
    cmd_t c0, c1;
    logic acc0 = 1'b0;
    logic acc1 = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!(m0_read || m0_write) || acc0) begin
                c0 = (q0.size() > 0) ? q0.pop_front() : '0;
                m0_read = c0.rd; m0_write = c0.wr; m0_address = c0.addr;
                m0_byteenable = c0.be; m0_writedata = c0.data;
            end
            if (!(m1_read || m1_write) || acc1) begin
                c1 = (q1.size() > 0) ? q1.pop_front() : '0;
                m1_read = c1.rd; m1_write = c1.wr; m1_address = c1.addr;
                m1_byteenable = c1.be; m1_writedata = c1.data;
            end
        end
    end

    task automatic apply_stimulus(int m, logic rd, logic wr, logic [12:0] a, logic [3:0] be, logic [31:0] d);
        cmd_t c;
        c = '{rd: rd, wr: wr, addr: a, be: be, data: d};
        if (m == 0) q0.push_back(c);
        else q1.push_back(c);
    endtask

    // Reference model state: who won last, the outstanding read and the intended memory image.
    logic        checking = 1'b0;
    int          last_winner = 1;
    logic        pend_valid = 1'b0;
    int          pend_owner = 0;
    logic [31:0] pend_data = '0;
    int          conflicts = 0;
    logic [31:0] shadow [0:DEPTH-1];

    logic [31:0] log0[$];
    logic [31:0] log1[$];
    int          waits0 = 0;
    int          waits1 = 0;
    logic [7:0]  grant_pat = '0;
    logic        cs_oor_seen = 1'b0;

    logic        req0, req1, s_rd, s_wr, inr, exp_cs, exp_v0, exp_v1;
    int          win;
    logic [12:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wd;

    always @(negedge clk) begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        acc0 = req0 && !m0_waitrequest;
        acc1 = req1 && !m1_waitrequest;
        if (checking) begin
            if (req0 && req1) win = (last_winner == 0) ? 1 : 0;
            else if (req0)    win = 0;
            else if (req1)    win = 1;
            else              win = -1;
            s_rd   = (win == 1) ? m1_read       : m0_read;
            s_wr   = (win == 1) ? m1_write      : m0_write;
            s_addr = (win == 1) ? m1_address    : m0_address;
            s_be   = (win == 1) ? m1_byteenable : m0_byteenable;
            s_wd   = (win == 1) ? m1_writedata  : m0_writedata;
            inr    = int'(s_addr) < DEPTH;
            exp_cs = (win >= 0) && inr;
            exp_v0 = !reset && pend_valid && (pend_owner == 0);
            exp_v1 = !reset && pend_valid && (pend_owner == 1);

            check_output("m0_waitrequest", m0_waitrequest, req0 && (win != 0));
            check_output("m1_waitrequest", m1_waitrequest, req1 && (win != 1));
            check_output("m0_readdatavalid", m0_readdatavalid, exp_v0);
            check_output("m1_readdatavalid", m1_readdatavalid, exp_v1);
            check_output("m0_readdata", m0_readdata, exp_v0 ? pend_data : 32'd0);
            check_output("m1_readdata", m1_readdata, exp_v1 ? pend_data : 32'd0);
            check_output("mem_chipselect", mem_chipselect, exp_cs);
            check_output("mem_write", mem_write, exp_cs && s_wr);
            check_output("mem_clken", mem_clken, !reset);
            check_output("mem_address", mem_address, s_addr);
            check_output("mem_byteenable", mem_byteenable, s_be);
            check_output("mem_writedata", mem_writedata, s_wd);
            check_output("conflict_count", conflict_count, conflicts);

            if (acc0) grant_pat = {grant_pat[6:0], 1'b0};
            if (acc1) grant_pat = {grant_pat[6:0], 1'b1};
            if (m0_waitrequest) waits0++;
            if (m1_waitrequest) waits1++;
            if (m0_readdatavalid) log0.push_back(m0_readdata);
            if (m1_readdatavalid) log1.push_back(m1_readdata);
            if (mem_chipselect && int'(mem_address) >= DEPTH) cs_oor_seen = 1'b1;

            if (reset) begin
                last_winner = 1;
                pend_valid  = 1'b0;
                conflicts   = 0;
            end else begin
                if (win >= 0) last_winner = win;
                pend_valid = (win >= 0) && s_rd && !s_wr;
                pend_owner = win;
                pend_data  = 32'd0;
                if (inr) pend_data = shadow[s_addr];
                if (exp_cs && s_wr) shadow[s_addr] = merge_bytes(shadow[s_addr], s_wd, s_be);
                if (req0 && req1 && conflicts != 65535) conflicts++;
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m0_read || m0_write || m1_read || m1_write) && n < 5000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_output("drain_timeout", n >= 5000, 1'b0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    int n;
    int kind;
    int asel;
    logic [12:0] ra;

    initial begin
        m0_address = '0; m0_byteenable = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
        m1_address = '0; m1_byteenable = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
        b_m0_address = '0; b_m1_address = '0; b_m0_read = 1'b0; b_m1_read = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);

        repeat (2) @(posedge clk);
        #2;
        checking = 1'b1;
        check_output("reset_conflict_count", conflict_count, 32'd0);
        check_output("reset_m0_readdatavalid", m0_readdatavalid, 1'b0);
        check_output("reset_m1_readdata", m1_readdata, 32'd0);
        reset = 1'b0;

        // Single master write then read-back.
        log0.delete(); log1.delete(); waits0 = 0;
        apply_stimulus(0, 1'b0, 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF);
        apply_stimulus(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'd0);
        drain();
        check_output("t1_m0_waits", waits0, 32'd0);
        check_output("t1_m0_returns", log0.size(), 32'd1);
        if (log0.size() > 0) check_output("t1_m0_data", log0[0], 32'hDEADBEEF);
        check_output("t1_m1_returns", log1.size(), 32'd0);

        // Partial byte-enable write over all-ones.
        log0.delete();
        apply_stimulus(0, 1'b0, 1'b1, 13'h0020, 4'hF, 32'hFFFFFFFF);
        apply_stimulus(0, 1'b0, 1'b1, 13'h0020, 4'h5, 32'h11223344);
        apply_stimulus(0, 1'b1, 1'b0, 13'h0020, 4'hF, 32'd0);
        drain();
        check_output("t2_returns", log0.size(), 32'd1);
        if (log0.size() > 0) check_output("t2_be_data", log0[0], 32'hFF22FF44);

        // Round-robin contention straight out of reset.
        do_reset();
        log0.delete(); log1.delete(); waits0 = 0; waits1 = 0; grant_pat = '0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'd0);
            apply_stimulus(1, 1'b1, 1'b0, 13'h0020, 4'hF, 32'd0);
        end
        drain();
        check_output("t3_grant_order", grant_pat, 8'h55);
        check_output("t3_conflicts", conflict_count, 32'd7);
        check_output("t3_m0_waits", waits0, 32'd3);
        check_output("t3_m1_waits", waits1, 32'd4);
        check_output("t3_m0_returns", log0.size(), 32'd4);
        check_output("t3_m1_returns", log1.size(), 32'd4);
        if (log1.size() > 0) check_output("t3_m1_data", log1[0], 32'hFF22FF44);

        // Out-of-range write is dropped, out-of-range read returns zero.
        log0.delete(); cs_oor_seen = 1'b0;
        apply_stimulus(0, 1'b0, 1'b1, 13'd5000, 4'hF, 32'hCAFEF00D);
        apply_stimulus(0, 1'b1, 1'b0, 13'd5000, 4'hF, 32'd0);
        apply_stimulus(0, 1'b1, 1'b0, 13'd4999, 4'hF, 32'd0);
        drain();
        check_output("t4_oor_chipselect", cs_oor_seen, 1'b0);
        check_output("t4_returns", log0.size(), 32'd2);
        if (log0.size() > 1) begin
            check_output("t4_oor_data", log0[0], 32'd0);
            check_output("t4_last_word", log0[1], init_word(4999));
        end

        // Reset lands in the cycle m1's read is granted.
        log1.delete();
        apply_stimulus(1, 1'b1, 1'b0, 13'h0020, 4'hF, 32'd0);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!m1_read && n < 20);
        check_output("t5_issue_timeout", n >= 20, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_output("t5_no_return", log1.size(), 32'd0);
        check_output("t5_conflicts", conflict_count, 32'd0);
        grant_pat = '0;
        apply_stimulus(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'd0);
        apply_stimulus(1, 1'b1, 1'b0, 13'h0020, 4'hF, 32'd0);
        drain();
        check_output("t5_first_grant", grant_pat[1:0], 2'b01);
        check_output("t5_m1_returns", log1.size(), 32'd1);

        // Fixed priority: m0 streams for 6 cycles while m1 waits.
        do_reset();
        b_m0_address = 13'd1; b_m1_address = 13'd2;
        b_m0_read = 1'b1; b_m1_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output("fp_m1_wait", b_m1_waitrequest, 1'b1);
            check_output("fp_m0_wait", b_m0_waitrequest, 1'b0);
            if (i == 1) check_output("fp_m0_valid", b_m0_readdatavalid, 1'b1);
            @(posedge clk);
            #2;
        end
        b_m0_read = 1'b0;
        @(negedge clk);
        check_output("fp_m1_granted", b_m1_waitrequest, 1'b0);
        check_output("fp_chipselect", b_mem_chipselect, 1'b1);
        check_output("fp_address", b_mem_address, 13'd2);
        check_output("fp_conflicts", b_conflict_count, 32'd6);
        @(posedge clk);
        #2;
        b_m1_read = 1'b0;

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            for (int m = 0; m < 2; m++) begin
                kind = $urandom_range(0, 9);
                asel = $urandom_range(0, 9);
                if (asel < 6)      ra = 13'($urandom_range(0, 31));
                else if (asel < 9) ra = 13'($urandom_range(4990, 5010));
                else               ra = 13'($urandom_range(0, 8191));
                apply_stimulus(m, (kind >= 3 && kind <= 5) || kind == 9, kind >= 6, ra,
                               4'($urandom_range(0, 15)), $urandom);
            end
        end
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 5000) begin
            @(posedge clk);
            #2;
            reset = ($urandom_range(0, 79) == 0);
            n++;
        end
        reset = 1'b0;
        check_output("random_timeout", n >= 5000, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
